// File: rtl/arashi_mem_pkg.sv
// arashi_mem_pkg: shared types and constants for the arashi memory read scheduler.
package arashi_mem_pkg;
    localparam int MAX_THREAD_NUM_WIDTH = 4;
    typedef enum logic [1:0] {RUN, DRAIN, DONE} sched_state_e;
    typedef logic [MAX_THREAD_NUM_WIDTH-1:0] tid_t;
    function automatic int cred_w(input int max_out);
        return $clog2(max_out + 1);
    endfunction
endpackage

// File: rtl/arashi_rr_pick.sv
// arashi_rr_pick: rotate-priority picker, first eligible index at or after i_ptr (wrapping).
module arashi_rr_pick #(
    parameter int W = 2
) (
    input  logic [(1<<W)-1:0] i_elig,
    input  logic [W-1:0]      i_ptr,
    output logic [W-1:0]      o_win,
    output logic              o_any
);
    always_comb begin
        o_win = '0;
        for (int k = (1 << W) - 1; k >= 0; k--)
            if (i_elig[i_ptr + W'(k)]) o_win = i_ptr + W'(k);
    end
    assign o_any = |i_elig;
endmodule

// File: rtl/arashi_mem_sched.sv
// arashi_mem_sched: round-robin, credit-limited sharing of one memory read port with drain/flush.
// Optional ARASHI_MEM_SCHED_STATS_EN adds saturating grant/stall counters.
module arashi_mem_sched import arashi_mem_pkg::*; #(
    parameter int DATA_WIDTH       = 32,
    parameter int MEM_WIDTH        = 10,
    parameter int THREAD_NUM_WIDTH = 2,
    parameter int MAX_OUT          = 4
) (
    input  logic                                       clk,
    input  logic                                       rstn,
    input  logic [(1<<THREAD_NUM_WIDTH)-1:0]           req,
    input  logic [(1<<THREAD_NUM_WIDTH)*MEM_WIDTH-1:0] req_addr,
    output logic [(1<<THREAD_NUM_WIDTH)-1:0]           gnt,
    output logic                                       mem_rd_valid,
    input  logic                                       mem_rd_ready,
    output logic [MEM_WIDTH-1:0]                       mem_rd_addr,
    output logic [THREAD_NUM_WIDTH-1:0]                mem_rd_tid,
    input  logic                                       mem_rsp_valid,
    input  logic [THREAD_NUM_WIDTH-1:0]                mem_rsp_tid,
    input  logic [DATA_WIDTH-1:0]                      mem_rsp_data,
    output logic [(1<<THREAD_NUM_WIDTH)-1:0]           rsp_valid,
    output logic [DATA_WIDTH-1:0]                      rsp_data,
    input  logic                                       flush,
    output logic                                       flush_done,
`ifdef ARASHI_MEM_SCHED_STATS_EN
    output logic [31:0]                                stat_grants,
    output logic [31:0]                                stat_stalls,
`endif
    output logic                                       err_unexp
);
    localparam int TN = 1 << THREAD_NUM_WIDTH;
    localparam int CW = cred_w(MAX_OUT);
    localparam logic [CW-1:0] FULL = CW'(MAX_OUT);

    logic [CW-1:0]               r_credit [TN];
    logic [THREAD_NUM_WIDTH-1:0] r_ptr;
    sched_state_e                r_state;
    logic [TN-1:0]               w_elig;
    logic [THREAD_NUM_WIDTH-1:0] w_win;
    logic                        w_any, w_cap, w_take, w_idle;

    // The flush edge itself already blocks new captures.
    always_comb begin
        w_idle = !mem_rd_valid;
        for (int i = 0; i < TN; i++) begin
            w_elig[i] = req[i] && r_credit[i] != '0 && r_state == RUN && !flush;
            w_idle = w_idle && r_credit[i] == FULL;
        end
    end

    assign w_cap  = !mem_rd_valid || mem_rd_ready;
    assign w_take = w_cap && w_any;

    arashi_rr_pick #(.W(THREAD_NUM_WIDTH)) u_pick (
        .i_elig (w_elig),
        .i_ptr  (r_ptr),
        .o_win  (w_win),
        .o_any  (w_any)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt          <= '0;
            mem_rd_valid <= 1'b0;
            mem_rd_addr  <= '0;
            mem_rd_tid   <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            flush_done   <= 1'b0;
            err_unexp    <= 1'b0;
            r_ptr        <= '0;
            r_state      <= RUN;
            for (int i = 0; i < TN; i++) r_credit[i] <= FULL;
        end else begin
            gnt <= w_take ? TN'(1) << w_win : '0;
            if (w_cap) mem_rd_valid <= w_any;
            if (w_take) begin
                mem_rd_addr <= req_addr[int'(w_win)*MEM_WIDTH +: MEM_WIDTH];
                mem_rd_tid  <= w_win;
                r_ptr       <= w_win + 1'b1;
            end
            rsp_valid <= mem_rsp_valid ? TN'(1) << mem_rsp_tid : '0;
            if (mem_rsp_valid) rsp_data <= mem_rsp_data;
            // A response to a thread with full credit is unexpected and leaves the credit alone.
            for (int i = 0; i < TN; i++) begin
                if (mem_rsp_valid && mem_rsp_tid == THREAD_NUM_WIDTH'(i) && r_credit[i] == FULL)
                    err_unexp <= 1'b1;
                else if (mem_rsp_valid && mem_rsp_tid == THREAD_NUM_WIDTH'(i) && !(w_take && w_win == THREAD_NUM_WIDTH'(i)))
                    r_credit[i] <= r_credit[i] + 1'b1;
                else if (w_take && w_win == THREAD_NUM_WIDTH'(i) && !(mem_rsp_valid && mem_rsp_tid == THREAD_NUM_WIDTH'(i)))
                    r_credit[i] <= r_credit[i] - 1'b1;
            end
            if (r_state == RUN) begin
                if (flush) r_state <= DRAIN;
            end else if (r_state == DRAIN) begin
                if (w_idle) begin
                    r_state    <= DONE;
                    flush_done <= 1'b1;
                end
            end else begin
                r_state    <= RUN;
                flush_done <= 1'b0;
            end
        end
    end

`ifdef ARASHI_MEM_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_grants <= '0;
            stat_stalls <= '0;
        end else if (flush_done) begin
            stat_grants <= '0;
            stat_stalls <= '0;
        end else begin
            if (|gnt && stat_grants != '1) stat_grants <= stat_grants + 1'b1;
            if (mem_rd_valid && !mem_rd_ready && stat_stalls != '1) stat_stalls <= stat_stalls + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_arashi_mem_sched.sv
// tb_arashi_mem_sched: directed table plus hand sequences for arashi_mem_sched (4 threads, MAX_OUT=4).
module tb_arashi_mem_sched;
    localparam int DW = 32, MW = 10, TW = 2, TN = 4, MO = 4;

    logic              clk = 1'b0, rstn = 1'b0;
    logic [TN-1:0]     req;
    logic [TN*MW-1:0]  req_addr;
    logic [TN-1:0]     gnt, rsp_valid;
    logic              mem_rd_valid, mem_rd_ready, mem_rsp_valid, flush, flush_done, err_unexp;
    logic [MW-1:0]     mem_rd_addr;
    logic [TW-1:0]     mem_rd_tid, mem_rsp_tid;
    logic [DW-1:0]     mem_rsp_data, rsp_data;
    int                checks = 0, failures = 0, ng;

    always #5 clk = ~clk;

    arashi_mem_sched #(.DATA_WIDTH(DW), .MEM_WIDTH(MW), .THREAD_NUM_WIDTH(TW), .MAX_OUT(MO)) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_addr(req_addr), .gnt(gnt),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
        .mem_rd_tid(mem_rd_tid), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tid(mem_rsp_tid),
        .mem_rsp_data(mem_rsp_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .flush(flush), .flush_done(flush_done), .err_unexp(err_unexp)
    );

    typedef struct {
        logic [3:0]  req;
        logic        rdy;
        logic        rv;
        logic [1:0]  rt;
        logic [31:0] rd;
        logic [3:0]  e_gnt;
        logic        e_val;
        logic [1:0]  e_tid;
        logic [3:0]  e_rsp;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_addrs;
        for (int i = 0; i < TN; i++) req_addr[i*MW +: MW] = MW'(32'h100 + i);
    endtask

    task automatic idle_in;
        req = '0; mem_rd_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_tid = '0;
        mem_rsp_data = '0; flush = 1'b0;
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        idle_in();
        set_addrs();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic rsp(input logic v, input logic [1:0] t, input logic [31:0] d);
        mem_rsp_valid = v; mem_rsp_tid = t; mem_rsp_data = d;
    endtask

    initial begin
        tbl[0]  = '{4'hF, 1, 0, 0, 32'h0,        4'b0001, 1, 0, 4'b0000, 32'h0};
        tbl[1]  = '{4'hF, 1, 0, 0, 32'h0,        4'b0010, 1, 1, 4'b0000, 32'h0};
        tbl[2]  = '{4'hF, 1, 0, 0, 32'h0,        4'b0100, 1, 2, 4'b0000, 32'h0};
        tbl[3]  = '{4'hF, 1, 0, 0, 32'h0,        4'b1000, 1, 3, 4'b0000, 32'h0};
        tbl[4]  = '{4'hF, 1, 0, 0, 32'h0,        4'b0001, 1, 0, 4'b0000, 32'h0};
        tbl[5]  = '{4'h0, 1, 1, 0, 32'hDEAD0001, 4'b0000, 0, 0, 4'b0001, 32'hDEAD0001};
        tbl[6]  = '{4'hA, 1, 1, 3, 32'h33,       4'b0010, 1, 1, 4'b1000, 32'h33};
        tbl[7]  = '{4'hA, 0, 0, 0, 32'h0,        4'b0000, 1, 1, 4'b0000, 32'h33};
        tbl[8]  = '{4'hA, 1, 0, 0, 32'h0,        4'b1000, 1, 3, 4'b0000, 32'h33};
        tbl[9]  = '{4'hA, 1, 1, 2, 32'h22,       4'b0010, 1, 1, 4'b0100, 32'h22};
        tbl[10] = '{4'h2, 1, 0, 0, 32'h0,        4'b0010, 1, 1, 4'b0000, 32'h22};
        tbl[11] = '{4'h2, 1, 0, 0, 32'h0,        4'b0000, 0, 1, 4'b0000, 32'h22};
        tbl[12] = '{4'h2, 1, 1, 1, 32'h11,       4'b0000, 0, 1, 4'b0010, 32'h11};
        tbl[13] = '{4'h2, 1, 0, 0, 32'h0,        4'b0010, 1, 1, 4'b0000, 32'h11};

        do_reset();
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_valid", 32'(mem_rd_valid), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_flush_done", 32'(flush_done), 0);
        chk("reset_err", 32'(err_unexp), 0);

        for (int v = 0; v < 14; v++) begin
            req = tbl[v].req; mem_rd_ready = tbl[v].rdy;
            rsp(tbl[v].rv, tbl[v].rt, tbl[v].rd);
            tick();
            chk($sformatf("v%0d_gnt", v), 32'(gnt), 32'(tbl[v].e_gnt));
            chk($sformatf("v%0d_valid", v), 32'(mem_rd_valid), 32'(tbl[v].e_val));
            chk($sformatf("v%0d_tid", v), 32'(mem_rd_tid), 32'(tbl[v].e_tid));
            chk($sformatf("v%0d_addr", v), 32'(mem_rd_addr), 32'h100 + 32'(tbl[v].e_tid));
            chk($sformatf("v%0d_rsp_valid", v), 32'(rsp_valid), 32'(tbl[v].e_rsp));
            chk($sformatf("v%0d_rsp_data", v), rsp_data, tbl[v].e_rdata);
        end
        chk("table_err", 32'(err_unexp), 0);

        // unexpected response sets sticky error
        do_reset();
        rsp(1, 1, 32'h5A);
        tick();
        chk("unexp_rsp_valid", 32'(rsp_valid), 32'b0010);
        chk("unexp_rsp_data", rsp_data, 32'h5A);
        chk("unexp_err", 32'(err_unexp), 1);
        rsp(0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("unexp_err_sticky", 32'(err_unexp), 1);

        // async reset mid-traffic
        req = 4'hF;
        for (int i = 0; i < 4; i++) tick();
        rstn = 1'b0;
        #2;
        chk("arst_gnt", 32'(gnt), 0);
        chk("arst_valid", 32'(mem_rd_valid), 0);
        chk("arst_addr", 32'(mem_rd_addr), 0);
        chk("arst_tid", 32'(mem_rd_tid), 0);
        chk("arst_rsp_data", rsp_data, 0);
        chk("arst_err", 32'(err_unexp), 0);
        do_reset();

        // credit limit on a single thread
        req = 4'b0100;
        ng = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (gnt == 4'b0100) ng++;
        end
        chk("credit_grants", 32'(ng), 4);
        chk("credit_valid_low", 32'(mem_rd_valid), 0);
        rsp(1, 2, 32'h77);
        tick();
        chk("credit_rsp_nogrant", 32'(gnt), 0);
        rsp(0, 0, 0);
        tick();
        chk("credit_regrant", 32'(gnt), 32'b0100);
        chk("credit_regrant_err", 32'(err_unexp), 0);

        // backpressure hold
        do_reset();
        req_addr[0 +: MW] = 10'h155;
        req = 4'b0001; mem_rd_ready = 1'b0;
        tick();
        chk("stall_first_gnt", 32'(gnt), 32'b0001);
        req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall%0d_gnt", i), 32'(gnt), 0);
            chk($sformatf("stall%0d_valid", i), 32'(mem_rd_valid), 1);
            chk($sformatf("stall%0d_addr", i), 32'(mem_rd_addr), 32'h155);
            chk($sformatf("stall%0d_tid", i), 32'(mem_rd_tid), 0);
        end
        mem_rd_ready = 1'b1; req = 4'b1110;
        tick();
        chk("stall_release_gnt", 32'(gnt), 32'b0010);
        chk("stall_release_addr", 32'(mem_rd_addr), 32'h101);

        // drain with three reads in flight
        do_reset();
        req = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fl_gnt%0d", i), 32'(gnt), 32'(1) << i);
        end
        flush = 1'b1;
        tick();
        chk("fl_edge_gnt", 32'(gnt), 0);
        chk("fl_edge_valid", 32'(mem_rd_valid), 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("fl_drain%0d_gnt", i), 32'(gnt), 0);
            chk($sformatf("fl_drain%0d_done", i), 32'(flush_done), 0);
            flush = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            rsp(1, 2'(i), 32'(i));
            tick();
            chk($sformatf("fl_rsp%0d_done", i), 32'(flush_done), 0);
            chk($sformatf("fl_rsp%0d_gnt", i), 32'(gnt), 0);
        end
        chk("fl_last_rsp", 32'(rsp_valid), 32'b0100);
        rsp(0, 0, 0);
        tick();
        chk("fl_done_pulse", 32'(flush_done), 1);
        chk("fl_done_gnt", 32'(gnt), 0);
        tick();
        chk("fl_done_clear", 32'(flush_done), 0);
        tick();
        chk("fl_run_gnt", 32'(gnt), 32'b0001);
        chk("fl_err", 32'(err_unexp), 0);

        // empty flush completes two edges later
        do_reset();
        flush = 1'b1;
        tick();
        chk("efl_edge1", 32'(flush_done), 0);
        flush = 1'b0;
        tick();
        chk("efl_edge2", 32'(flush_done), 1);
        tick();
        chk("efl_edge3", 32'(flush_done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
